// File: rtl/velmshift_seq.sv
// velmshift_seq
//   Sequencer for a velmshifter_jump lane shifter. It takes one
//   "shift vector by N lanes" request and parallel-loads the vector into the
//   shifter. It then issues one shift (or jump) op per cycle until the distance
//   is covered, and presents the shifter contents on a valid/ready output.
//   Only one request is in flight at a time.
//
//   Optional feature macro: VELMSHIFT_SEQ_JUMP_EN
//     defined   : ops move JUMPSIZE lanes while the remaining count >= JUMPSIZE
//     undefined : sh_jump tied low, every op moves one lane
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     request handshake
//   in_data               vector to shift, lane i at [i*WIDTH +: WIDTH]
//   in_amt, in_dir_left   shift distance in lanes, 1 = toward higher lanes
//   out_valid/out_ready   result handshake
//   out_data              shifted vector, zero while out_valid is low
//   sh_*                  shifter control/data, sh_outpipe is read back
module velmshift_seq #(
  parameter int NUMLANES = 4,
  parameter int WIDTH    = 32,
  parameter int JUMPSIZE = 4,
  parameter int AMTW     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUMLANES*WIDTH-1:0] in_data,
  input  logic [AMTW-1:0]           in_amt,
  input  logic                      in_dir_left,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUMLANES*WIDTH-1:0] out_data,
  output logic                      sh_load,
  output logic                      sh_shift,
  output logic                      sh_jump,
  output logic                      sh_dir_left,
  output logic [NUMLANES*WIDTH-1:0] sh_inpipe,
  output logic [WIDTH-1:0]          sh_shiftin_left,
  output logic [WIDTH-1:0]          sh_shiftin_right,
  input  logic [NUMLANES*WIDTH-1:0] sh_outpipe
);

  localparam int CW = $clog2(NUMLANES + 1);
  localparam logic [CW-1:0] LANES_C = CW'(NUMLANES);
  localparam logic [CW-1:0] JSTEP   = CW'(JUMPSIZE);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          dir;
  logic [CW-1:0] eff;
  logic          use_jump;
  logic [CW-1:0] step;

  // Distances past the lane count all produce an all-zero vector, so clamp.
  always_comb begin
    eff = LANES_C;
    if (in_amt < AMTW'(NUMLANES)) eff = in_amt[CW-1:0];
  end

`ifdef VELMSHIFT_SEQ_JUMP_EN
  assign use_jump = (cnt >= JSTEP);
`else
  assign use_jump = 1'b0;
`endif

  // cnt >= 1 in SHIFT and step is 1 whenever cnt < JUMPSIZE, so no underflow.
  assign step = use_jump ? JSTEP : CW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      dir   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          dir   <= in_dir_left;
          cnt   <= eff;
          state <= (eff == '0) ? S_DONE : S_SHIFT;
        end
        S_SHIFT: begin
          cnt <= cnt - step;
          if (cnt == step) state <= S_DONE;
        end
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode from the registered state. They are gated by reset so that
  // everything reads zero while reset is held, including in_ready.
  assign in_ready         = !reset && (state == S_IDLE);
  assign sh_load          = in_valid && in_ready;
  assign sh_shift         = !reset && (state == S_SHIFT);
  assign sh_jump          = sh_shift && use_jump;
  assign sh_dir_left      = sh_shift && dir;
  assign sh_inpipe        = reset ? '0 : in_data;
  assign sh_shiftin_left  = '0;
  assign sh_shiftin_right = '0;
  assign out_valid        = !reset && (state == S_DONE);
  assign out_data         = out_valid ? sh_outpipe : '0;

endmodule

// File: tb/tb_velmshift_seq.sv
module tb_velmshift_seq;
  localparam int NL = 4, W = 32, JS = 4, AW = 8;
  localparam logic [127:0] D = {32'h44, 32'h33, 32'h22, 32'h11};

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, in_dir_left;
  logic [127:0]  in_data;
  logic [AW-1:0] in_amt;
  logic          out_valid, out_ready;
  logic [127:0]  out_data;
  logic          sh_load, sh_shift, sh_jump, sh_dir_left;
  logic [127:0]  sh_inpipe, sh_outpipe;
  logic [W-1:0]  sh_shiftin_left, sh_shiftin_right;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  velmshift_seq #(.NUMLANES(NL), .WIDTH(W), .JUMPSIZE(JS), .AMTW(AW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_dir_left(in_dir_left),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sh_load(sh_load), .sh_shift(sh_shift), .sh_jump(sh_jump),
    .sh_dir_left(sh_dir_left), .sh_inpipe(sh_inpipe),
    .sh_shiftin_left(sh_shiftin_left), .sh_shiftin_right(sh_shiftin_right),
    .sh_outpipe(sh_outpipe)
  );

  // Behavioural stand-in for the lane shifter (zero fill, reset clears).
  logic [127:0] sreg;
  always_ff @(posedge clk) begin
    if (reset) sreg <= '0;
    else if (sh_load) sreg <= sh_inpipe;
    else if (sh_shift) begin
      if (sh_dir_left) sreg <= sreg << ((sh_jump ? JS : 1) * W);
      else             sreg <= sreg >> ((sh_jump ? JS : 1) * W);
    end
  end
  assign sh_outpipe = sreg;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Issue one request from IDLE and follow it to the first out_valid cycle.
  // Leaves the bench at the negedge of the first DONE cycle.
  task automatic run(input string tag, input int amt, input bit left,
                     input int exp_k, input int exp_j, input logic [127:0] exp_d);
    int ops = 0, jumps = 0, cyc = 0;
    bit ctl_ok = 1'b1;
    in_valid = 1'b1; in_amt = AW'(amt); in_dir_left = left; in_data = D;
    mid();
    chk({tag, "_ready"}, 128'(in_ready), 128'(1));
    chk({tag, "_load"}, 128'(sh_load), 128'(1));
    chk({tag, "_inpipe"}, sh_inpipe, D);
    step();
    in_valid = 1'b0;
    mid();
    while (!out_valid && cyc < 20) begin
      if (sh_shift) ops++;
      if (sh_jump) jumps++;
      if (sh_load || !sh_shift || sh_dir_left != left || in_ready) ctl_ok = 1'b0;
      step(); mid();
      cyc++;
    end
    chk({tag, "_latency"}, 128'(cyc), 128'(exp_k));
    chk({tag, "_ops"}, 128'(ops), 128'(exp_k));
    chk({tag, "_jumps"}, 128'(jumps), 128'(exp_j));
    chk({tag, "_ctl"}, 128'(ctl_ok), 128'(1));
    chk({tag, "_valid"}, 128'(out_valid), 128'(1));
    chk({tag, "_data"}, out_data, exp_d);
    chk({tag, "_done_ctl"}, 128'({in_ready, sh_shift, sh_load}), 128'(0));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b1; in_amt = '0; in_dir_left = 1'b0;
    in_data = D; out_ready = 1'b1;
    mid();
    chk("rst_ready", 128'(in_ready), 128'(0));
    chk("rst_load", 128'(sh_load), 128'(0));
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_data", out_data, 128'(0));
    step(); step();
    reset = 1'b0; in_valid = 1'b0;
    mid();
    chk("post_rst_ready", 128'(in_ready), 128'(1));
    step();

    run("amt1_left", 1, 1'b1, 1, 0, {32'h33, 32'h22, 32'h11, 32'h0});
    step(); mid();
    chk("amt1_back_idle", 128'({in_ready, out_valid}), 128'(2'b10));
    chk("amt1_data_zero", out_data, 128'(0));
    step();

    run("amt0", 0, 1'b1, 0, 0, D);
    step(); step();
    run("amt3_right", 3, 1'b0, 3, 0, {32'h0, 32'h0, 32'h0, 32'h44});
    step(); step();
    run("amt2_right", 2, 1'b0, 2, 0, {32'h0, 32'h0, 32'h44, 32'h33});
    step(); step();
`ifdef VELMSHIFT_SEQ_JUMP_EN
    run("amt9_left", 9, 1'b1, 1, 1, 128'(0));
`else
    run("amt9_left", 9, 1'b1, 4, 0, 128'(0));
`endif
    step(); step();

    // Backpressure: hold in DONE with a competing request pending.
    out_ready = 1'b0;
    run("bp", 1, 1'b1, 1, 0, {32'h33, 32'h22, 32'h11, 32'h0});
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(); mid();
      chk("bp_hold_valid", 128'(out_valid), 128'(1));
      chk("bp_hold_data", out_data, {32'h33, 32'h22, 32'h11, 32'h0});
      chk("bp_hold_ready", 128'({in_ready, sh_load}), 128'(0));
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    mid();
    chk("bp_release_ready", 128'(in_ready), 128'(1));
    chk("bp_release_valid", 128'(out_valid), 128'(0));
    step();

    // Reset during the second SHIFT cycle of an amount-3 request.
    in_valid = 1'b1; in_amt = 8'd3; in_dir_left = 1'b0; in_data = D;
    step();
    in_valid = 1'b0;
    step();
    reset = 1'b1;
    mid();
    chk("midrst_outs", 128'({out_valid, sh_shift, in_ready}), 128'(0));
    step();
    reset = 1'b0;
    mid();
    chk("midrst_ready", 128'(in_ready), 128'(1));
    chk("midrst_shreg", sh_outpipe, 128'(0));
    for (int i = 0; i < 4; i++) begin
      step(); mid();
      chk("midrst_no_valid", 128'(out_valid), 128'(0));
    end
    step();
    run("after_rst", 1, 1'b1, 1, 0, {32'h33, 32'h22, 32'h11, 32'h0});
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
